// File: rtl/aes_core_sched.sv
`default_nettype none
// ============================================================================
// Module      : aes_core_sched
// Description : Sequencing controller between the input message packer and
//               the AES-128 core. It collects a 4-beat plaintext/key burst
//               into 128-bit registers and fires a one-cycle start pulse at
//               the core. It then waits for completion, bounded by a timeout,
//               and drains the ciphertext as four words under valid/ready.
//               Protocol violations are recorded in sticky error flags.
//
// Ports       : clk, rst_n              clock, async active-low reset
//               in_pt_word/in_key_word  plaintext/key beats, MSW first
//               in_dv                   beat valid (4 consecutive cycles)
//               core_pt_out/key_out     registered block to the core
//               core_start              one-cycle start pulse
//               core_done/core_ct_in    completion strobe + ciphertext
//               out_word/out_dv         ciphertext beat, MSW first
//               out_ready               downstream accepts current beat
//               busy                    high whenever not IDLE
//               err_flags               [0] burst gap, [1] core timeout,
//                                       [2] input overrun (sticky)
//               err_clr                 synchronous clear of err_flags
//
// Revision    : 1.0 - initial release
// ============================================================================
module aes_core_sched #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   in_pt_word,
    input  logic [DATA_WIDTH-1:0]   in_key_word,
    input  logic                    in_dv,
    output logic [4*DATA_WIDTH-1:0] core_pt_out,
    output logic [4*DATA_WIDTH-1:0] core_key_out,
    output logic                    core_start,
    input  logic                    core_done,
    input  logic [4*DATA_WIDTH-1:0] core_ct_in,
    output logic [DATA_WIDTH-1:0]   out_word,
    output logic                    out_dv,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [2:0]              err_flags,
    input  logic                    err_clr
);

    localparam int         C_BLOCK_W     = 4 * DATA_WIDTH;
    // Last wait_cnt value tolerated before the core is declared hung.
    localparam logic [7:0] C_WAIT_LAST   = 8'(TIMEOUT_CYCLES - 1);
    localparam int         C_ERR_GAP     = 0;
    localparam int         C_ERR_TIMEOUT = 1;
    localparam int         C_ERR_OVERRUN = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_SEND  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [C_BLOCK_W-1:0]   r_pt;
    logic [C_BLOCK_W-1:0]   r_key;
    logic [C_BLOCK_W-1:0]   r_result;
    logic [1:0]             r_beat_cnt;
    logic [1:0]             r_out_idx;
    logic [7:0]             r_wait_cnt;
    logic [2:0]             r_err;

    logic                   w_capture;
    logic [1:0]             w_cap_idx;
    logic                   w_wait_clr;
    logic                   w_wait_inc;
    logic                   w_ct_latch;
    logic                   w_out_adv;
    logic [2:0]             w_err_set;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_cap_idx   = r_beat_cnt;
        w_wait_clr  = 1'b0;
        w_wait_inc  = 1'b0;
        w_ct_latch  = 1'b0;
        w_out_adv   = 1'b0;
        w_err_set   = 3'b000;

        case (r_state)
            S_IDLE: begin
                // A stale beat_cnt can be left behind by an aborted burst,
                // so the first beat always lands in the top word.
                w_cap_idx = 2'd0;
                if (in_dv) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end

            S_LOAD: begin
                if (in_dv) begin
                    w_capture = 1'b1;
                    if (r_beat_cnt == 2'd3) begin
                        w_state_nxt = S_START;
                    end
                end else begin
                    w_err_set[C_ERR_GAP] = 1'b1;
                    w_state_nxt          = S_IDLE;
                end
            end

            S_START: begin
                w_wait_clr                = 1'b1;
                w_err_set[C_ERR_OVERRUN]  = in_dv;
                w_state_nxt               = S_WAIT;
            end

            S_WAIT: begin
                w_err_set[C_ERR_OVERRUN] = in_dv;
                // Done takes priority over an expiring timeout.
                if (core_done) begin
                    w_ct_latch  = 1'b1;
                    w_state_nxt = S_SEND;
                end else if (r_wait_cnt == C_WAIT_LAST) begin
                    w_err_set[C_ERR_TIMEOUT] = 1'b1;
                    w_state_nxt              = S_IDLE;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end

            S_SEND: begin
                w_err_set[C_ERR_OVERRUN] = in_dv;
                if (out_ready) begin
                    w_out_adv = 1'b1;
                    if (r_out_idx == 2'd3) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pt       <= '0;
            r_key      <= '0;
            r_result   <= '0;
            r_beat_cnt <= 2'd0;
            r_out_idx  <= 2'd0;
            r_wait_cnt <= 8'd0;
        end else begin
            if (w_capture) begin
                r_pt[C_BLOCK_W-1 - DATA_WIDTH*int'(w_cap_idx) -: DATA_WIDTH]  <= in_pt_word;
                r_key[C_BLOCK_W-1 - DATA_WIDTH*int'(w_cap_idx) -: DATA_WIDTH] <= in_key_word;
                // Wraps back to 0 after beat 3.
                r_beat_cnt <= w_cap_idx + 2'd1;
            end

            if (w_wait_clr) begin
                r_wait_cnt <= 8'd0;
            end else if (w_wait_inc) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            if (w_ct_latch) begin
                r_result  <= core_ct_in;
                r_out_idx <= 2'd0;
            end else if (w_out_adv) begin
                r_out_idx <= r_out_idx + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a set in the same cycle as err_clr survives.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 3'b000;
        end else begin
            r_err <= (err_clr ? 3'b000 : r_err) | w_err_set;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        core_start = (r_state == S_START);
        out_dv     = (r_state == S_SEND);
        busy       = (r_state != S_IDLE);
        out_word   = '0;
        // Word is gated so nothing stale leaks out outside SEND.
        if (r_state == S_SEND) begin
            out_word = r_result[C_BLOCK_W-1 - DATA_WIDTH*int'(r_out_idx) -: DATA_WIDTH];
        end
    end

    assign core_pt_out  = r_pt;
    assign core_key_out = r_key;
    assign err_flags    = r_err;

endmodule
`default_nettype wire
